// File: rtl/serial_byte_rx_pkg.sv
// rtl/serial_byte_rx_pkg.sv - shared constants and types for the serial byte receiver
package serial_byte_rx_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    // Bit-order encoding shared with the upstream shift-register stage
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } asm_state_t;

endpackage

// File: rtl/serial_byte_rx_if.sv
// rtl/serial_byte_rx_if.sv - serial bit input and word output bundle of the receiver
interface serial_byte_rx_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr;
    logic             dir;
    logic             bit_en;
    logic             bit_in;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             busy;
    logic             ovf;

    modport master (
        output clr, dir, bit_en, bit_in, out_ready,
        input  out_data, out_valid, count, busy, ovf
    );

    modport slave (
        input  clr, dir, bit_en, bit_in, out_ready,
        output out_data, out_valid, count, busy, ovf
    );
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush, fill count and zeroed head when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop_ok  = pop & ~empty & ~flush;
    // A full FIFO still accepts a push when the head leaves at the same edge
    assign push_ok = push & ~flush & (~full | pop_ok);

    assign count    = cnt;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/serial_byte_rx.sv
// rtl/serial_byte_rx.sv - serial-to-parallel word assembler feeding a valid/ready FIFO
module serial_byte_rx
    import serial_byte_rx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    serial_byte_rx_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    asm_state_t       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] asm_q;
    logic             dir_lat;
    logic             ovf_q;

    logic             eff_dir;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic             fifo_full;
    logic             fifo_empty;
    logic             ovf_set;

    // The first bit of a word uses the live dir; later bits use the latched order
    assign eff_dir   = (state == ST_IDLE) ? bus.dir : dir_lat;
    assign shifted   = (eff_dir == DIR_LSB_FIRST) ? {bus.bit_in, asm_q[WIDTH-1:1]}
                                                  : {asm_q[WIDTH-2:0], bus.bit_in};
    assign word_done = bus.bit_en & ~bus.clr & (bit_cnt == LAST_BIT);
    // When full the FIFO is non-empty, so out_ready alone means the head leaves
    assign ovf_set   = word_done & fifo_full & ~bus.out_ready;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (bus.clr),
        .push      (word_done),
        .push_data (shifted),
        .pop       (bus.out_ready),
        .pop_data  (bus.out_data),
        .count     (bus.count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.out_valid = ~fifo_empty;
    assign bus.busy      = (state == ST_SHIFT);
    assign bus.ovf       = ovf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            asm_q   <= '0;
            dir_lat <= DIR_MSB_FIRST;
            ovf_q   <= 1'b0;
        end else if (bus.clr) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (bus.bit_en) begin
                asm_q <= shifted;
                if (state == ST_IDLE) begin
                    dir_lat <= bus.dir;
                end
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    state   <= ST_IDLE;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    state   <= ST_SHIFT;
                end
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_byte_rx.sv
// tb/tb_serial_byte_rx.sv - directed self-checking bench for serial_byte_rx
module tb_serial_byte_rx;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    serial_byte_rx_if #(.WIDTH(8), .DEPTH(4)) bus ();

    serial_byte_rx #(.WIDTH(8), .DEPTH(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       dir;
        logic [7:0] seq;
        int         gap;
        logic       toggle;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // seq[7] is sent first; rdy_last raises out_ready on the final bit's edge
    task automatic send_word(input logic d, input logic [7:0] seq, input int gap,
                             input logic toggle, input logic rdy_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) bus.dir = d;
            else if (toggle && i == 4) bus.dir = ~d;
            bus.bit_in = seq[7-i];
            bus.bit_en = 1'b1;
            if (i == 7 && rdy_last) bus.out_ready = 1'b1;
            tick();
            bus.bit_en    = 1'b0;
            bus.out_ready = 1'b0;
            if (i < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    check("busy_gap", bus.busy, 1);
                end
            end
        end
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{"msb_0f",    1'b0, 8'h0F, 0, 1'b0, 8'h0F};
        vecs[1] = '{"lsb_f0",    1'b1, 8'h0F, 0, 1'b0, 8'hF0};
        vecs[2] = '{"lsb_toggle",1'b1, 8'h0F, 0, 1'b1, 8'hF0};
        vecs[3] = '{"msb_gap2",  1'b0, 8'h0F, 2, 1'b0, 8'h0F};
        vecs[4] = '{"lsb_55",    1'b1, 8'hAA, 0, 1'b0, 8'h55};
        vecs[5] = '{"lsb_01",    1'b1, 8'h80, 0, 1'b1, 8'h01};
        vecs[6] = '{"msb_3c_gap",1'b0, 8'h3C, 1, 1'b1, 8'h3C};

        reset_n = 1'b0;
        bus.clr = 1'b0; bus.dir = 1'b0; bus.bit_en = 1'b0; bus.bit_in = 1'b0; bus.out_ready = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_data",  bus.out_data, 0);
        check("rst_count", bus.count, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_ovf",   bus.ovf, 0);
        pop_one();
        check("empty_pop_count", bus.count, 0);

        // Reset mid-word with one word already queued
        send_word(1'b0, 8'h0F, 0, 1'b0, 1'b0);
        check("pre_rst_valid", bus.out_valid, 1);
        for (int i = 0; i < 3; i++) begin
            bus.bit_in = 1'b1; bus.bit_en = 1'b1; tick();
        end
        bus.bit_en = 1'b0;
        check("pre_rst_busy", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_data",  bus.out_data, 0);
        check("arst_count", bus.count, 0);
        check("arst_busy",  bus.busy, 0);
        tick();
        reset_n = 1'b1;
        send_word(1'b0, 8'hA5, 0, 1'b0, 1'b0);
        check("post_rst_data",  bus.out_data, 8'hA5);
        check("post_rst_count", bus.count, 1);
        pop_one();
        check("post_rst_empty", bus.out_valid, 0);

        // Table-driven words
        foreach (vecs[k]) begin
            send_word(vecs[k].dir, vecs[k].seq, vecs[k].gap, vecs[k].toggle, 1'b0);
            check({vecs[k].name, "_valid"}, bus.out_valid, 1);
            check({vecs[k].name, "_data"},  bus.out_data, vecs[k].exp);
            check({vecs[k].name, "_count"}, bus.count, 1);
            check({vecs[k].name, "_busy"},  bus.busy, 0);
            pop_one();
            check({vecs[k].name, "_drain"}, bus.count, 0);
        end

        // Overflow: fifth word is lost
        for (int w = 1; w <= 5; w++) send_word(1'b0, 8'(w), 0, 1'b0, 1'b0);
        check("ovf_count", bus.count, 4);
        check("ovf_flag",  bus.ovf, 1);
        for (int w = 1; w <= 4; w++) begin
            check("ovf_order", bus.out_data, w);
            pop_one();
        end
        check("ovf_empty", bus.out_valid, 0);
        check("ovf_sticky", bus.ovf, 1);
        bus.clr = 1'b1; tick(); bus.clr = 1'b0;
        check("clr_ovf", bus.ovf, 0);

        // Full FIFO with push and pop at the same edge
        send_word(1'b0, 8'h11, 0, 1'b0, 1'b0);
        send_word(1'b0, 8'h22, 0, 1'b0, 1'b0);
        send_word(1'b0, 8'h33, 0, 1'b0, 1'b0);
        send_word(1'b0, 8'h44, 0, 1'b0, 1'b0);
        send_word(1'b0, 8'h55, 0, 1'b0, 1'b1);
        check("full_pp_count", bus.count, 4);
        check("full_pp_ovf",   bus.ovf, 0);
        for (int w = 2; w <= 5; w++) begin
            check("full_pp_order", bus.out_data, 8'h11 * w);
            pop_one();
        end
        check("full_pp_empty", bus.count, 0);

        // clr after 5 bits with 2 words queued, bit_en also high
        send_word(1'b0, 8'h12, 0, 1'b0, 1'b0);
        send_word(1'b0, 8'h34, 0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.bit_in = 1'b1; bus.bit_en = 1'b1; tick();
        end
        bus.clr = 1'b1; tick();
        bus.clr = 1'b0; bus.bit_en = 1'b0;
        check("clr_busy",  bus.busy, 0);
        check("clr_count", bus.count, 0);
        check("clr_valid", bus.out_valid, 0);
        send_word(1'b0, 8'hAA, 0, 1'b0, 1'b0);
        check("clr_aa_data",  bus.out_data, 8'hAA);
        check("clr_aa_count", bus.count, 1);

        // Word completing in a clr cycle on a full FIFO: discarded, no ovf
        for (int w = 0; w < 3; w++) send_word(1'b0, 8'h70, 0, 1'b0, 1'b0);
        check("clr_full_count", bus.count, 4);
        for (int i = 0; i < 7; i++) begin
            bus.bit_in = 1'b0; bus.bit_en = 1'b1; tick();
        end
        bus.clr = 1'b1; tick();
        bus.clr = 1'b0; bus.bit_en = 1'b0;
        check("clr_last_ovf",   bus.ovf, 0);
        check("clr_last_count", bus.count, 0);
        check("clr_last_busy",  bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
